toggle_pulse_gen: RTL and testbench

Generates the toggle-enable stream `t` for the downstream T flip-flop stage, such as the team's divide-by-2 toggle cell. A start request launches a run. The run issues single-cycle `t` pulses at a programmable period, either for a fixed burst count or continuously until stopped. Status outputs (`busy`, `done`, `pulse_cnt`) let a controller sequence several toggle stages.

---
 rtl/tpg_pkg.sv | 13 +
 rtl/tpg_period_cnt.sv | 42 ++++
 rtl/toggle_pulse_gen.sv | 116 +++++++++++
 tb/tb_toggle_pulse_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// toggle_pulse_gen shared types and width defaults.
// Imported by the period counter and the top level.
package tpg_pkg;

  localparam int TPG_CNT_W   = 8;
  localparam int TPG_BURST_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tpg_state_e;

endpackage

// File: rtl/tpg_period_cnt.sv
// Loadable down-counter that paces the toggle pulses.
// Zero flag marks the cycle a pulse is due.
module tpg_period_cnt
  import tpg_pkg::*;
#(
  parameter int CNT_W = TPG_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins; otherwise count down, holding at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/toggle_pulse_gen.sv
// Toggle-enable pulse generator for a downstream T flip-flop stage.
// Issues t pulses every P_eff cycles for a burst or until stopped.
module toggle_pulse_gen
  import tpg_pkg::*;
#(
  parameter int CNT_W   = TPG_CNT_W,
  parameter int BURST_W = TPG_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst,
  output logic               t,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0]   P_ONE = CNT_W'(1);
  localparam logic [BURST_W-1:0] B_ONE = BURST_W'(1);

  tpg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic               t_q, t_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_en;
  logic               cnt_zero;

  tpg_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // next state, latched run settings and output values
  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    burst_d      = burst_q;
    pcnt_d       = pcnt_q;
    t_d          = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = reload_q;
    cnt_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d      = ST_RUN;
          reload_d     = (period == '0) ? '0 : period - P_ONE;
          burst_d      = burst;
          pcnt_d       = '0;
          cnt_load     = 1'b1;
          cnt_load_val = reload_d;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          t_d      = 1'b1;
          cnt_load = 1'b1;
          pcnt_d   = pcnt_q + B_ONE;
          if ((burst_q != '0) && (pcnt_d == burst_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      burst_q  <= '0;
      pcnt_q   <= '0;
      t_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      burst_q  <= burst_d;
      pcnt_q   <= pcnt_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign t         = t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Randomized and directed bench for toggle_pulse_gen.
// Reference model derives pulses from elapsed cycles since start.
module tb_toggle_pulse_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] period;
  logic [7:0] burst;
  logic       t;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  int vectors;
  int errors;
  int edge_n;

  // model state
  logic m_active;
  int   m_k;
  int   m_p;
  int   m_b;
  logic m_t;
  logic m_busy;
  logic m_done;
  logic [7:0] m_pcnt;

  toggle_pulse_gen #(
    .CNT_W   (8),
    .BURST_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .burst     (burst),
    .t         (t),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] act();
    return {t, busy, done, pulse_cnt};
  endfunction

  function automatic logic [10:0] expv();
    return {m_t, m_busy, m_done, m_pcnt};
  endfunction

  // outputs after one edge, from elapsed-time arithmetic
  task automatic model_step(input logic rs, st, sp,
                            input logic [7:0] per, bur);
    int d;
    int n;
    m_t    = 1'b0;
    m_done = 1'b0;
    if (rs) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
      m_pcnt   = '0;
    end else if (m_active) begin
      if (sp) begin
        m_active = 1'b0;
        m_busy   = 1'b0;
      end else begin
        d = edge_n - m_k;
        m_busy = 1'b1;
        if (d % m_p == 0) begin
          n      = d / m_p;
          m_t    = 1'b1;
          m_pcnt = 8'(n);
          if (m_b != 0 && n == m_b) begin
            m_done   = 1'b1;
            m_busy   = 1'b0;
            m_active = 1'b0;
          end
        end
      end
    end else begin
      m_busy = 1'b0;
      if (st && !sp) begin
        m_active = 1'b1;
        m_k      = edge_n;
        m_p      = (per == 0) ? 1 : int'(per);
        m_b      = int'(bur);
        m_pcnt   = '0;
        m_busy   = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic rs, st, sp,
                      input logic [7:0] per, bur);
    reset  = rs;
    start  = st;
    stop   = sp;
    period = per;
    burst  = bur;
    @(posedge clk);
    edge_n++;
    model_step(rs, st, sp, per, bur);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      vectors++;
      if (act() !== 11'h0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=000", edge_n, act());
      end
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_fixed_burst();
    tick(1'b0, 1'b1, 1'b0, 8'd3, 8'd2);
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL fixed_burst cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
      tick(1'b0, 1'b0, 1'b0, 8'd7, 8'd9);
    end
    vectors++;
    if (pulse_cnt !== 8'd2) begin
      errors++;
      $display("FAIL burst_final_cnt got=%0d exp=2", pulse_cnt);
    end
  endtask

  task automatic test_period01();
    for (int p = 0; p < 2; p++) begin
      tick(1'b0, 1'b1, 1'b0, 8'(p), 8'd4);
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (act() !== expv()) begin
          errors++;
          $display("FAIL period%0d cyc=%0d got=%h exp=%h",
                   p, edge_n, act(), expv());
        end
        tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      end
    end
  endtask

  task automatic test_stop();
    int k;
    tick(1'b0, 1'b1, 1'b0, 8'd5, 8'd0);
    k = edge_n;
    while (edge_n < k + 14) begin
      vectors++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL stop cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
      tick(1'b0, 1'b0, (edge_n + 1 == k + 10), 8'd5, 8'd0);
    end
    vectors++;
    if (pulse_cnt !== 8'd1) begin
      errors++;
      $display("FAIL stop_cnt got=%0d exp=1", pulse_cnt);
    end
  endtask

  task automatic test_ignored();
    tick(1'b0, 1'b1, 1'b0, 8'd4, 8'd2);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL restart cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
      tick(1'b0, (i == 2), 1'b0, 8'd1, 8'd7);
    end
    tick(1'b0, 1'b1, 1'b1, 8'd2, 8'd2);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (act() !== expv() || busy !== 1'b0) begin
        errors++;
        $display("FAIL start_stop cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
      tick(1'b0, 1'b0, 1'b0, 8'd2, 8'd2);
    end
  endtask

  task automatic test_reset_midrun();
    tick(1'b0, 1'b1, 1'b0, 8'd3, 8'd3);
    for (int i = 1; i <= 8; i++) begin
      tick((i == 4), 1'b0, 1'b0, 8'd3, 8'd3);
      vectors++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'd2, 8'd1);
      vectors++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
      vectors++;
      if (act() !== expv() || t !== 1'b1) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
    end
    tick(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    vectors++;
    if (act() !== expv()) begin
      errors++;
      $display("FAIL wrap_stop got=%h exp=%h", act(), expv());
    end
  endtask

  task automatic test_random();
    logic rs, st, sp;
    logic [7:0] per, bur;
    for (int i = 0; i < 2000; i++) begin
      rs  = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 39) == 0);
      per = 8'($urandom_range(0, 6));
      bur = 8'($urandom_range(0, 5));
      tick(rs, st, sp, per, bur);
      vectors++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 edge_n, act(), expv());
      end
    end
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    edge_n   = 0;
    m_active = 1'b0;
    m_k      = 0;
    m_p      = 1;
    m_b      = 0;
    m_t      = 1'b0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_pcnt   = '0;
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    period   = '0;
    burst    = '0;
    test_reset();
    test_fixed_burst();
    test_period01();
    test_stop();
    test_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
